// File: rtl/minibyte_uart_tx.sv
// Minibyte memory-mapped UART transmitter: TXDATA/STATUS decode, TX FIFO and an 8N1 shifter.
// Define MINIBYTE_UART_PARITY_EN to add an even-parity bit per frame, advertised in STATUS[7].
module minibyte_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [6:0]  BASE_ADDR    = 7'h7C
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       we_in,
    output logic [7:0] data_out,
    output logic       rd_sel_out,
    output logic       tx_out,
    output logic       busy_out
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0]  Depth    = CntW'(FIFO_DEPTH);
    localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]       StatAddr = BASE_ADDR + 7'd1;

`ifdef MINIBYTE_UART_PARITY_EN
    localparam logic ParityEn = 1'b1;
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    localparam logic ParityEn = 1'b0;
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             ovf_q, ovf_d;
    logic             we_q;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef MINIBYTE_UART_PARITY_EN
    logic             par_q, par_d;
`endif

    logic       txdata_sel, status_sel, wr_stb, push_req, push, pop;
    logic       flush, clr_ovf, full, empty, baud_end;
    logic [7:0] head, status;

    assign txdata_sel = (addr_in == BASE_ADDR);
    assign status_sel = (addr_in == StatAddr);
    assign wr_stb     = we_in & ~we_q;
    assign push_req   = wr_stb & txdata_sel;
    assign flush      = wr_stb & status_sel & data_in[0];
    assign clr_ovf    = wr_stb & status_sel & data_in[1];
    assign full       = (cnt_q == Depth);
    assign empty      = (cnt_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign baud_end   = (baud_q == BaudMax);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push       = push_req & (~full | pop);

    assign status     = {ParityEn, 3'(cnt_q), ovf_q, state_q != StIdle, empty, full};
    assign data_out   = status_sel ? status : 8'h00;
    assign rd_sel_out = txdata_sel | status_sel;
    assign tx_out     = tx_q;
    assign busy_out   = busy_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) state_d = StData;
            end
            StData: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef MINIBYTE_UART_PARITY_EN
                    if (bit_q == 3'd7) state_d = StParity;
`else
                    if (bit_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef MINIBYTE_UART_PARITY_EN
            StParity: begin
                if (baud_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Bit timer restarts at every bit boundary and stays cleared while idle.
        baud_d = (state_q == StIdle || baud_end) ? '0 : baud_q + 1'b1;
        if (pop) begin
            shift_d = head;
            bit_d   = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (push_req && !push) begin
            ovf_d = 1'b1;
        end
    end

`ifdef MINIBYTE_UART_PARITY_EN
    assign par_d = pop ? ^head : par_q;
`endif

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef MINIBYTE_UART_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign busy_d = (state_d != StIdle) | (cnt_d != '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b1;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef MINIBYTE_UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            we_q     <= we_in;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef MINIBYTE_UART_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

endmodule
